// File: rtl/pe_array_ctrl.sv
// Sequencer for a motion-estimation PE array: loads current blocks into two
// ping-pong banks, preloads the reference path, then steps the search positions.
module pe_array_ctrl #(
    parameter int LOAD_LEN    = 16,
    parameter int PRELOAD_LEN = 8,
    parameter int SEARCH_POS  = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       more_blk,
    input  logic       cb_valid,
    output logic       in_curr_enable,
    output logic       CB_select,
    output logic [1:0] abs_Control,
    output logic       change_ref,
    output logic       ref_input_control,
    output logic       sad_valid,
    output logic [7:0] search_pos,
    output logic       busy,
    output logic       blk_done
);

    localparam int LW = $clog2(LOAD_LEN + 1);
    localparam int PW = $clog2(PRELOAD_LEN + 1);

    // Bank encoding matches CB_select: 1 = bank A, 0 = bank B.
    localparam logic BANK_A = 1'b1;
    localparam logic BANK_B = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PRELOAD,
        SEARCH,
        WAIT_LOAD
    } state_t;

    state_t          state_q, state_d;
    logic            load_bank_q, search_bank_q;
    logic [LW-1:0]   load_cnt_q;
    logic [PW-1:0]   pre_cnt_q;
    logic [7:0]      pos_q;
    logic            phase_q;
    logic            sad_valid_q;

    logic load_full, load_gate, beat, load_done_next, last_pos, pre_last;

    assign load_full = (load_cnt_q == LW'(LOAD_LEN));
    assign load_gate = cb_valid & more_blk & ~load_full;
    assign last_pos  = (pos_q == 8'(SEARCH_POS - 1));
    assign pre_last  = (pre_cnt_q == PW'(PRELOAD_LEN - 1));

    // An accepted beat is cb_valid qualified by the load strobe of the current state.
    always_comb begin
        beat = 1'b0;
        case (state_q)
            LOAD:              beat = cb_valid;
            SEARCH, WAIT_LOAD: beat = load_gate;
            default:           beat = 1'b0;
        endcase
    end

    // Counts the beat accepted this cycle, so a load finishing on the last
    // search cycle goes straight to PRELOAD instead of detouring through WAIT_LOAD.
    assign load_done_next = load_full | (beat & (load_cnt_q == LW'(LOAD_LEN - 1)));

    assign in_curr_enable = beat;
    assign CB_select      = load_bank_q;
    assign search_pos     = pos_q;
    assign sad_valid      = sad_valid_q;
    assign busy           = (state_q != IDLE);

    // NOTE: every output and state_d gets a default first so no path can infer a latch.
    always_comb begin
        state_d           = state_q;
        abs_Control       = 2'b00;
        change_ref        = 1'b0;
        ref_input_control = 1'b0;
        blk_done          = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                if (beat && load_cnt_q == LW'(LOAD_LEN - 1)) state_d = PRELOAD;
            end
            PRELOAD: begin
                change_ref        = 1'b1;
                ref_input_control = 1'b1;
                if (pre_last) state_d = SEARCH;
            end
            SEARCH: begin
                abs_Control = {search_bank_q == BANK_B, phase_q};
                if (phase_q) begin
                    change_ref = 1'b1;
                    if (last_pos) begin
                        blk_done = 1'b1;
                        if (!more_blk)          state_d = IDLE;
                        else if (load_done_next) state_d = PRELOAD;
                        else                     state_d = WAIT_LOAD;
                    end
                end
            end
            WAIT_LOAD: begin
                if (load_done_next) state_d = PRELOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; later
    // assignments in this block deliberately override the counter updates above them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            load_bank_q   <= BANK_A;
            search_bank_q <= BANK_A;
            load_cnt_q    <= '0;
            pre_cnt_q     <= '0;
            pos_q         <= '0;
            phase_q       <= 1'b0;
            sad_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sad_valid_q <= (state_q == SEARCH);

            if (beat && !load_full) load_cnt_q <= load_cnt_q + 1'b1;

            if (state_q == PRELOAD && !pre_last) pre_cnt_q <= pre_cnt_q + 1'b1;

            if (state_q == SEARCH) begin
                phase_q <= ~phase_q;
                if (phase_q && !last_pos) pos_q <= pos_q + 8'd1;
            end

            if (state_q == SEARCH && state_d != SEARCH) begin
                pos_q   <= '0;
                phase_q <= 1'b0;
            end

            // Entering PRELOAD: the bank just loaded becomes the search bank.
            if (state_d == PRELOAD && state_q != PRELOAD) begin
                search_bank_q <= load_bank_q;
                load_bank_q   <= ~load_bank_q;
                load_cnt_q    <= '0;
                pre_cnt_q     <= '0;
            end

            if (state_d == IDLE && state_q != IDLE) begin
                load_bank_q   <= BANK_A;
                search_bank_q <= BANK_A;
                load_cnt_q    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Directed bench for pe_array_ctrl with LOAD_LEN=4, PRELOAD_LEN=2, SEARCH_POS=3;
// every cycle's expected outputs are hand-written vectors.
module tb_pe_array_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       more_blk;
    logic       cb_valid;
    logic       in_curr_enable;
    logic       CB_select;
    logic [1:0] abs_Control;
    logic       change_ref;
    logic       ref_input_control;
    logic       sad_valid;
    logic [7:0] search_pos;
    logic       busy;
    logic       blk_done;

    int n_tests = 0;
    int n_fail  = 0;
    int bd_seen = 0;

    pe_array_ctrl #(
        .LOAD_LEN   (4),
        .PRELOAD_LEN(2),
        .SEARCH_POS (3)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .more_blk         (more_blk),
        .cb_valid         (cb_valid),
        .in_curr_enable   (in_curr_enable),
        .CB_select        (CB_select),
        .abs_Control      (abs_Control),
        .change_ref       (change_ref),
        .ref_input_control(ref_input_control),
        .sad_valid        (sad_valid),
        .search_pos       (search_pos),
        .busy             (busy),
        .blk_done         (blk_done)
    );

    always #5 clk = ~clk;

    // Vector layout: {busy, in_curr_enable, CB_select, change_ref, ref_input_control, abs_Control, sad_valid, blk_done}
    logic [8:0] obs;
    assign obs = {busy, in_curr_enable, CB_select, change_ref, ref_input_control,
                  abs_Control, sad_valid, blk_done};

    localparam logic [8:0] V_IDLE   = 9'b0_0_1_0_0_00_0_0;
    localparam logic [8:0] V_IDLE_S = 9'b0_0_1_0_0_00_1_0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, let outputs settle, compare, advance to edge+1.
    task automatic cyc(input logic s, input logic cb, input logic mb,
                       input logic [8:0] ev, input logic [7:0] ep, input string tag);
        start    = s;
        cb_valid = cb;
        more_blk = mb;
        #1;
        check(tag, obs, ev);
        check({tag, "_pos"}, search_pos, ep);
        if (blk_done) bd_seen++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        start = 1'b0;
        while (busy && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(tag, busy, 1'b0);
        @(posedge clk);
        #1;
    endtask

    // Single block, cb_valid=1, more_blk=0. extra_start pulses start again at
    // that cycle index; rst_at asserts reset during that cycle and stops there.
    task automatic run_single(input string name, input int extra_start, input int rst_at);
        logic [8:0] ev [15];
        logic [7:0] ep [15];
        ev = '{9'b0_0_1_0_0_00_0_0,
               9'b1_1_1_0_0_00_0_0, 9'b1_1_1_0_0_00_0_0, 9'b1_1_1_0_0_00_0_0, 9'b1_1_1_0_0_00_0_0,
               9'b1_0_0_1_1_00_0_0, 9'b1_0_0_1_1_00_0_0,
               9'b1_0_0_0_0_00_0_0, 9'b1_0_0_1_0_01_1_0,
               9'b1_0_0_0_0_00_1_0, 9'b1_0_0_1_0_01_1_0,
               9'b1_0_0_0_0_00_1_0, 9'b1_0_0_1_0_01_1_1,
               9'b0_0_1_0_0_00_1_0, 9'b0_0_1_0_0_00_0_0};
        ep = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
               8'd1, 8'd1, 8'd2, 8'd2, 8'd0, 8'd0};
        bd_seen = 0;
        for (int i = 0; i < 15; i++) begin
            rst = (i == rst_at);
            cyc((i == 0) || (i == extra_start), 1'b1, 1'b0, ev[i], ep[i],
                $sformatf("%s_c%0d", name, i));
            rst = 1'b0;
            if (i == rst_at) begin
                cyc(1'b0, 1'b1, 1'b0, V_IDLE, 8'd0, $sformatf("%s_after_rst", name));
                return;
            end
        end
        check({name, "_blk_done_cnt"}, bd_seen, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; more_blk = 1'b0; cb_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_vec", obs, V_IDLE);
        check("reset_pos", search_pos, 8'd0);
        rst = 1'b0;

        run_single("single", -1, -1);

        // Two blocks: bank B loads during search 1, search 2 reads bank B.
        bd_seen = 0;
        cyc(1, 1, 1, 9'b0_0_1_0_0_00_0_0, 0, "two_c0");
        for (int i = 1; i <= 4; i++) cyc(0, 1, 1, 9'b1_1_1_0_0_00_0_0, 0, $sformatf("two_load%0d", i));
        cyc(0, 1, 1, 9'b1_0_0_1_1_00_0_0, 0, "two_pre1a");
        cyc(0, 1, 1, 9'b1_0_0_1_1_00_0_0, 0, "two_pre1b");
        cyc(0, 1, 1, 9'b1_1_0_0_0_00_0_0, 0, "two_s1_c0");
        cyc(0, 1, 1, 9'b1_1_0_1_0_01_1_0, 0, "two_s1_c1");
        cyc(0, 1, 1, 9'b1_1_0_0_0_00_1_0, 1, "two_s1_c2");
        cyc(0, 1, 1, 9'b1_1_0_1_0_01_1_0, 1, "two_s1_c3");
        cyc(0, 1, 1, 9'b1_0_0_0_0_00_1_0, 2, "two_s1_c4");
        cyc(0, 1, 1, 9'b1_0_0_1_0_01_1_1, 2, "two_s1_c5");
        cyc(0, 1, 0, 9'b1_0_1_1_1_00_1_0, 0, "two_pre2a");
        cyc(0, 1, 0, 9'b1_0_1_1_1_00_0_0, 0, "two_pre2b");
        cyc(0, 1, 0, 9'b1_0_1_0_0_10_0_0, 0, "two_s2_c0");
        cyc(0, 1, 0, 9'b1_0_1_1_0_11_1_0, 0, "two_s2_c1");
        cyc(0, 1, 0, 9'b1_0_1_0_0_10_1_0, 1, "two_s2_c2");
        cyc(0, 1, 0, 9'b1_0_1_1_0_11_1_0, 1, "two_s2_c3");
        cyc(0, 1, 0, 9'b1_0_1_0_0_10_1_0, 2, "two_s2_c4");
        cyc(0, 1, 0, 9'b1_0_1_1_0_11_1_1, 2, "two_s2_c5");
        cyc(0, 1, 0, V_IDLE_S, 0, "two_idle0");
        cyc(0, 1, 0, V_IDLE, 0, "two_idle1");
        check("two_blk_done_cnt", bd_seen, 2);

        // Alternating cb_valid in LOAD: 4 beats over 7 cycles, then PRELOAD.
        cyc(1, 0, 0, V_IDLE, 0, "alt_c0");
        for (int i = 1; i <= 7; i++)
            cyc(0, i[0], 0, i[0] ? 9'b1_1_1_0_0_00_0_0 : 9'b1_0_1_0_0_00_0_0, 0,
                $sformatf("alt_load%0d", i));
        cyc(0, 0, 0, 9'b1_0_0_1_1_00_0_0, 0, "alt_pre");
        wait_idle("alt_idle");

        // Bank-B load held off until search end -> WAIT_LOAD.
        cyc(1, 1, 1, V_IDLE, 0, "wl_c0");
        for (int i = 1; i <= 4; i++) cyc(0, 1, 1, 9'b1_1_1_0_0_00_0_0, 0, $sformatf("wl_load%0d", i));
        cyc(0, 0, 1, 9'b1_0_0_1_1_00_0_0, 0, "wl_pre1a");
        cyc(0, 0, 1, 9'b1_0_0_1_1_00_0_0, 0, "wl_pre1b");
        cyc(0, 0, 1, 9'b1_0_0_0_0_00_0_0, 0, "wl_s_c0");
        cyc(0, 0, 1, 9'b1_0_0_1_0_01_1_0, 0, "wl_s_c1");
        cyc(0, 0, 1, 9'b1_0_0_0_0_00_1_0, 1, "wl_s_c2");
        cyc(0, 0, 1, 9'b1_0_0_1_0_01_1_0, 1, "wl_s_c3");
        cyc(0, 0, 1, 9'b1_0_0_0_0_00_1_0, 2, "wl_s_c4");
        cyc(0, 0, 1, 9'b1_0_0_1_0_01_1_1, 2, "wl_s_c5");
        cyc(0, 0, 1, 9'b1_0_0_0_0_00_1_0, 0, "wl_wait0");
        for (int i = 1; i <= 4; i++) cyc(0, 1, 1, 9'b1_1_0_0_0_00_0_0, 0, $sformatf("wl_beat%0d", i));
        cyc(0, 1, 0, 9'b1_0_1_1_1_00_0_0, 0, "wl_pre2a");
        cyc(0, 1, 0, 9'b1_0_1_1_1_00_0_0, 0, "wl_pre2b");
        cyc(0, 1, 0, 9'b1_0_1_0_0_10_0_0, 0, "wl_s2_c0");
        wait_idle("wl_idle");

        // Reset while search_pos = 1, then a clean block.
        run_single("rst_mid", -1, 9);
        run_single("post_rst", -1, -1);

        // start pulsed mid-search is ignored.
        run_single("start_in_search", 9, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
